shared_mix_ring: RTL and testbench
==================================

Name: shared_mix_ring

Overview:
- Parametrised successor to the fixed 4-cell feedback mixer used in the shared-L3 area.
- A ring of DEPTH registered cells of WIDTH bits; cell ops alternate XOR/ADD with neighbour feedback, and the last cell adds constant K.
- Adds over the fixed version: valid/ready stream handshake, gated or free-running step mode, synchronous clear, warm-up qualification of the output.

Parameters:
- WIDTH, 32, data width of input, cells and output.
- DEPTH, 4, number of cells; legal range 2..16.
- K, 32'hA5A5A5A5, additive constant for the last cell, truncated to WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- clear  input  1  synchronous state clear, same effect as rst.
- mode  input  1  0 = gated (step only on accepted input word); 1 = free-run (step every cycle in_ready is high).
- in_valid  input  1  input word present.
- in_data  input  WIDTH  input word.
- in_ready  output  1  block can step this cycle.
- out_valid  output  1  out_data is a qualified result.
- out_data  output  WIDTH  value of cell DEPTH-1.
- out_ready  input  1  downstream accepts out_data.

Behaviour:
- Reset (rst=1): all cells = 0, warm-up counter = 0, out_valid = 0, out_data = 0. rst has priority over everything.
- clear=1 has the same effect as rst. clear beats a step in the same cycle; the input word is not consumed. in_ready is still driven combinationally in that cycle.
- in_ready = !out_valid || out_ready (combinational).
- step:
  - mode 0: step = in_valid && in_ready.
  - mode 1: step = in_ready.
- Injected word x on a step: x = in_data if in_valid, else 0. In mode 1, in_valid=0 injects 0.
- Cell update on a step, all cells simultaneously from old values; all arithmetic mod 2^WIDTH, carries discarded:
  - s[0] <= x ^ s[1].
  - For 0 < i < DEPTH-1: s[i] <= s[i-1] + s[i+1] when i is odd; s[i] <= s[i-1] ^ s[i+1] when i is even.
  - s[DEPTH-1] <= s[DEPTH-2] + K.
  - DEPTH=2 reduces to s0 <= x ^ s1 and s1 <= s0 + K.
- No step: cells hold.
- Warm-up counter: width clog2(DEPTH+1), increments per step, saturates at DEPTH.
- out_valid:
  - Set on the step that brings the counter to DEPTH, and on every later step.
  - Cleared when out_ready=1 and no step occurs that cycle.
  - Once warm, a step while out_valid && out_ready replaces the word (back-to-back throughput 1/cycle).
- Latency: first out_valid is the cycle after the DEPTH-th step.
- out_data = s[DEPTH-1] continuously, so it is stable while out_valid=1 and out_ready=0 (no step possible).
- Mode change takes effect on the next cycle's step decision and does not disturb cells or counter.
- Backpressure: out_valid=1 and out_ready=0 forces in_ready=0 and no step in either mode.

Decomposition:
- Package shared_mix_pkg:
  - default WIDTH/DEPTH/K localparams;
  - mode encoding constants MODE_GATED=0, MODE_FREE=1;
  - op-select function: odd index = ADD, even index = XOR.
- One sub-module, shared_mix_cell: a WIDTH-bit register with step enable, clear, and a parameter selecting XOR or ADD of its two operands.
- The top-level generate loop instantiates DEPTH cells and holds the handshake and counter logic.

Test Plan:
- Defaults, rst, mode 0, four zero words with out_ready=1 -> out_valid first high after 4th step; out_data=32'h4B4B4B4A, s2=32'hEEEEEEEF.
- Continue with a 5th zero word -> out_data=32'h94949494 (ADD overflow wraps), out_valid stays 1.
- Warm ring, out_ready=0, in_valid=1 held -> in_ready=0, out_data frozen for 10 cycles; raise out_ready -> exactly one step next cycle.
- mode 1, in_valid=0 from reset, out_ready=1 -> cells step every cycle; out_data matches the gated zero-word sequence (A5A5A5A5, A5A5A5A5, 4B4B4B4A, ...).
- clear asserted together with a valid step mid-stream -> next cycle all cells 0, out_valid=0, input word not consumed; warm-up restarts and needs 4 steps.
- DEPTH=2, K=8'h01, WIDTH=8, inputs 3 then 0 -> step1: s0=3, s1=01; step2: s0=01, s1=04, out_valid=1.

Source files
------------

// File: rtl/shared_mix_pkg.sv
// Shared definitions for the shared-L3 feedback mixer ring.
// Defaults, mode encoding and per-cell operator selection.
package shared_mix_pkg;

  localparam int          DEF_WIDTH = 32;
  localparam int          DEF_DEPTH = 4;
  localparam logic [31:0] DEF_K     = 32'hA5A5A5A5;

  localparam logic MODE_GATED = 1'b0;
  localparam logic MODE_FREE  = 1'b1;

  typedef enum logic {
    OP_XOR = 1'b0,
    OP_ADD = 1'b1
  } op_e;

  function automatic op_e cell_op(input int idx);
    return (idx % 2 == 1) ? OP_ADD : OP_XOR;
  endfunction

endpackage

// File: rtl/shared_mix_cell.sv
// One ring cell: WIDTH-bit register loading a XOR or ADD of its
// two operands when enabled; clear and reset both zero it.
module shared_mix_cell
  import shared_mix_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter op_e OP    = OP_XOR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] res;

  always_comb begin
    res = (OP == OP_ADD) ? (a + b) : (a ^ b);
    q_d = en ? res : q_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shared_mix_ring.sv
// Parametrised feedback mixer ring with valid/ready handshake,
// gated or free-running stepping and warm-up output qualification.
module shared_mix_ring
  import shared_mix_pkg::*;
#(
  parameter int          WIDTH = DEF_WIDTH,
  parameter int          DEPTH = DEF_DEPTH,
  parameter logic [31:0] K     = DEF_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);
  localparam logic [WIDTH-1:0] K_W   = WIDTH'(K);

  logic [DEPTH-1:0][WIDTH-1:0] s;
  logic                        step;
  logic [WIDTH-1:0]            x;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_d;
  logic                        out_valid_q;
  logic                        out_valid_d;

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    step        = (mode == MODE_FREE) ? in_ready
                                      : (in_valid && in_ready);
    x           = in_valid ? in_data : '0;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    if (step) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      out_valid_d = (cnt_d == CNT_MAX);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Every cell updates from the old ring values in the same cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    if (i == 0) begin : g_first
      assign a = x;
      assign b = s[1];
    end else if (i == DEPTH - 1) begin : g_last
      assign a = s[i-1];
      assign b = K_W;
    end else begin : g_mid
      assign a = s[i-1];
      assign b = s[i+1];
    end

    shared_mix_cell #(
      .WIDTH (WIDTH),
      .OP    ((i == DEPTH - 1) ? OP_ADD : cell_op(i))
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .en    (step),
      .a     (a),
      .b     (b),
      .q     (s[i])
    );
  end

  assign out_valid = out_valid_q;
  assign out_data  = s[DEPTH-1];

endmodule

// File: tb/tb_shared_mix_ring.sv
// Bench for shared_mix_ring: spec vector table, behavioural model
// with an expected-output scoreboard, and a DEPTH=2 instance.
module tb_shared_mix_ring;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        mode;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  logic        b_mode;
  logic        b_in_valid;
  logic [7:0]  b_in_data;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic        b_out_ready;

  shared_mix_ring dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  shared_mix_ring #(
    .WIDTH (8),
    .DEPTH (2),
    .K     (32'h01)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .mode      (b_mode),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_ready (b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        clr;
    logic        md;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_do;
  } row_t;

  exp_t        sb[$];
  int          n_run;
  int          n_fail;
  logic [31:0] m_s[4];
  int          m_cnt;
  logic        m_ov;
  logic        last_rdy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_s[i] = '0;
    m_cnt = 0;
    m_ov  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0;
    mode = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, predict with the model, push the
  // expectation, then pop and compare after the edge.
  task automatic cyc(input logic c, input logic md, input logic iv,
                     input logic [31:0] din, input logic ordy,
                     input string tag);
    logic        rdy_e;
    logic        stp;
    logic [31:0] nx[4];
    exp_t        e;
    clear = c;
    mode = md;
    in_valid = iv;
    in_data = din;
    out_ready = ordy;
    #1;
    last_rdy = in_ready;
    rdy_e = !m_ov || ordy;
    chk({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, rdy_e});
    stp = md ? rdy_e : (iv && rdy_e);
    if (c) begin
      model_reset();
    end else if (stp) begin
      nx[0] = (iv ? din : 32'h0) ^ m_s[1];
      for (int i = 1; i < 3; i++) begin
        if (i % 2 == 1) nx[i] = m_s[i-1] + m_s[i+1];
        else            nx[i] = m_s[i-1] ^ m_s[i+1];
      end
      nx[3] = m_s[2] + K;
      m_s = nx;
      if (m_cnt < 4) m_cnt++;
      m_ov = (m_cnt == 4);
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    e.ov = m_ov;
    e.data = m_s[3];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, e.ov});
    chk({tag, " out_data"}, out_data, e.data);
  endtask

  row_t        tbl[6];
  logic [31:0] m1_exp[3];

  initial begin
    n_run = 0;
    n_fail = 0;
    b_mode = 1'b0;
    b_in_valid = 1'b0;
    b_in_data = '0;
    b_out_ready = 1'b1;
    do_reset();

    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset in_ready", {31'b0, in_ready}, 32'h1);

    // DEPTH=2, WIDTH=8, K=1: inputs 3 then 0 then 0.
    b_in_valid = 1'b1;
    b_in_data = 8'd3;
    @(posedge clk); #1;
    chk("d2 step1 data", {24'b0, b_out_data}, 32'h01);
    chk("d2 step1 valid", {31'b0, b_out_valid}, 32'h0);
    b_in_data = 8'd0;
    @(posedge clk); #1;
    chk("d2 step2 data", {24'b0, b_out_data}, 32'h04);
    chk("d2 step2 valid", {31'b0, b_out_valid}, 32'h1);
    @(posedge clk); #1;
    chk("d2 step3 data", {24'b0, b_out_data}, 32'h02);
    b_in_valid = 1'b0;

    // Gated zero words, then backpressure begins.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h4B4B4B4A};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4B4B4B4A};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h94949494};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h94949494};
    for (int r = 0; r < 6; r++) begin
      cyc(tbl[r].clr, tbl[r].md, tbl[r].iv, tbl[r].din, tbl[r].ordy,
          $sformatf("tbl%0d", r));
      chk($sformatf("tbl%0d rdy", r), {31'b0, last_rdy},
          {31'b0, tbl[r].exp_rdy});
      chk($sformatf("tbl%0d ov", r), {31'b0, out_valid},
          {31'b0, tbl[r].exp_ov});
      chk($sformatf("tbl%0d do", r), out_data, tbl[r].exp_do);
    end

    // Held backpressure: frozen output, then exactly one step.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b0, "bp hold");
      chk("bp frozen", out_data, 32'h94949494);
    end
    cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, "bp release");
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "bp idle");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, "bp drain");

    // Clear beats a valid step; warm-up restarts.
    cyc(1'b0, 1'b0, 1'b1, 32'h13579BDF, 1'b1, "pre clr");
    cyc(1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, "clr");
    chk("clr data zero", out_data, 32'h0);
    chk("clr valid zero", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, "rewarm");
    chk("rewarm not valid", {31'b0, out_valid}, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, "rewarm4");
    chk("rewarm4 valid", {31'b0, out_valid}, 32'h1);
    chk("rewarm4 data", out_data, 32'h4B4B4B4A);

    // Free-run with no input words follows the zero-word sequence.
    do_reset();
    m1_exp[0] = 32'hA5A5A5A5;
    m1_exp[1] = 32'hA5A5A5A5;
    m1_exp[2] = 32'h4B4B4B4A;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, "free");
      if (i < 3) chk($sformatf("free%0d const", i), out_data, m1_exp[i]);
    end

    // Mixed random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
